raccoon_master: RTL and testbench

Ring-side request initiator for the Raccoon bus: accepts single load/store requests from a simple req/ack client (CPU or testbench driver) and inserts them as 79-bit packets into empty ring slots. It removes the matching response from the ring and returns read data to the client. It sits upstream of the ring's slave bridges (e.g. Raccoon-to-AXI32), which consume its request packets and produce the response packets it captures. One outstanding transaction.

---
 rtl/raccoon_pkg.sv | 34 +++
 rtl/raccoon_master.sv | 170 +++++++++++++++++
 tb/tb_raccoon_master.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/raccoon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : raccoon_pkg
// Description : Shared definitions for the Raccoon ring master: packet width,
//               packet field bit positions and the master FSM state type.
// Contents    : c_pkt_w          - ring packet width (79)
//               c_valid..c_addr_* - field bit positions inside a packet
//               state_t          - master FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package raccoon_pkg;

  localparam int c_pkt_w    = 79;

  localparam int c_valid    = 78;
  localparam int c_write    = 77;
  localparam int c_resp     = 76;
  localparam int c_id_msb   = 75;
  localparam int c_id_lsb   = 68;
  localparam int c_mask_msb = 67;
  localparam int c_mask_lsb = 64;
  localparam int c_data_msb = 63;
  localparam int c_data_lsb = 32;
  localparam int c_addr_msb = 31;
  localparam int c_addr_lsb = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INSERT = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

endpackage : raccoon_pkg
`default_nettype wire

// File: rtl/raccoon_master.sv
`default_nettype none
// ============================================================================
// Module      : raccoon_master
// Description : Ring-side request initiator for the Raccoon bus. Takes one
//               load/store at a time from a req/ack client, inserts it as a
//               request packet into the first empty ring slot, removes the
//               matching response and returns read data to the client.
//               Responses carrying this master's ID that do not match the
//               outstanding transaction are removed silently.
// Ports       : CLK, RST_N        - clock, asynchronous active-low reset
//               RaccIn / RaccOut  - ring packet in / out (output registered)
//               REQ, WR, ADDR,
//               WDATA, MASK       - client request, held until ACK
//               ACK, RDATA, ERR   - one-cycle completion, read data, timeout
// Options     : RACCOON_MASTER_TIMEOUT_EN - when defined, WAIT gives up after
//               TIMEOUT_CYCLES cycles and completes with ERR=1.
// Revision    : 1.0 - initial release
// ============================================================================
module raccoon_master
  import raccoon_pkg::*;
#(
  parameter logic [5:0]  MASTER_ID      = 6'd1,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [c_pkt_w-1:0] RaccIn,
  output logic [c_pkt_w-1:0] RaccOut,
  input  logic               REQ,
  input  logic               WR,
  input  logic [31:0]        ADDR,
  input  logic [31:0]        WDATA,
  input  logic [3:0]         MASK,
  output logic               ACK,
  output logic [31:0]        RDATA,
  output logic               ERR
);

  state_t               r_state;
  logic [c_pkt_w-1:0]   r_din;
  logic [c_pkt_w-1:0]   r_out;
  logic [1:0]           r_seq;
  logic [7:0]           r_cur_id;
  logic                 r_wr;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [3:0]           r_mask;
  logic                 r_ack;
  logic [31:0]          r_rdata;
  logic                 r_err;

  logic                 w_is_resp;
  logic                 w_match;
  logic                 w_stale;
  logic                 w_tmo_hit;
  logic [c_pkt_w-1:0]   w_req_pkt;

  // A response is ours if its ID carries MASTER_ID in the upper bits; only the
  // one whose full ID equals the outstanding transaction (and only in WAIT)
  // completes it, every other one of ours is left over from an abandoned
  // transaction and is pulled off the ring.
  assign w_is_resp = r_din[c_valid] && r_din[c_resp];
  assign w_match   = (r_state == ST_WAIT) && w_is_resp &&
                     (r_din[c_id_msb:c_id_lsb] == r_cur_id);
  assign w_stale   = w_is_resp && !w_match &&
                     (r_din[c_id_msb:c_id_msb-5] == MASTER_ID);

  always_comb begin
    w_req_pkt                         = '0;
    w_req_pkt[c_valid]                = 1'b1;
    w_req_pkt[c_write]                = r_wr;
    w_req_pkt[c_resp]                 = 1'b0;
    w_req_pkt[c_id_msb:c_id_lsb]      = {MASTER_ID, r_seq};
    w_req_pkt[c_mask_msb:c_mask_lsb]  = r_mask;
    w_req_pkt[c_data_msb:c_data_lsb]  = r_wdata;
    w_req_pkt[c_addr_msb:c_addr_lsb]  = r_addr;
  end

`ifdef RACCOON_MASTER_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;

  // Held at zero outside WAIT, so the first WAIT cycle sees a count of zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_tmo_cnt <= 16'd0;
    end else if (r_state != ST_WAIT) begin
      r_tmo_cnt <= 16'd0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  assign w_tmo_hit = (r_state == ST_WAIT) && (r_tmo_cnt == TIMEOUT_CYCLES - 16'd1);
`else
  // No timeout: WAIT lasts until the response arrives. TIMEOUT_CYCLES is
  // still referenced so both builds share one parameter list.
  assign w_tmo_hit = 1'b0 && (TIMEOUT_CYCLES != 16'd0);
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= ST_IDLE;
      r_din    <= '0;
      r_out    <= '0;
      r_seq    <= 2'd0;
      r_cur_id <= 8'd0;
      r_wr     <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_mask   <= 4'd0;
      r_ack    <= 1'b0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_din <= RaccIn;
      r_ack <= 1'b0;
      // Default ring behaviour: drop our stale responses, forward the rest.
      r_out <= w_stale ? '0 : r_din;

      unique case (r_state)
        ST_IDLE: begin
          // ACK gating keeps a REQ still high during the completion cycle
          // from starting a second copy of the same transaction.
          if (REQ && !r_ack) begin
            r_wr    <= WR;
            r_addr  <= ADDR;
            r_wdata <= WDATA;
            r_mask  <= MASK;
            r_state <= ST_INSERT;
          end
        end

        ST_INSERT: begin
          if (!r_din[c_valid]) begin
            r_out    <= w_req_pkt;
            r_cur_id <= {MASTER_ID, r_seq};
            r_seq    <= r_seq + 2'd1;
            r_state  <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (w_match) begin
            r_out   <= '0;
            r_rdata <= r_din[c_write] ? 32'd0 : r_din[c_data_msb:c_data_lsb];
            r_err   <= 1'b0;
            r_ack   <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_tmo_hit) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b1;
            r_ack   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign RaccOut = r_out;
  assign ACK     = r_ack;
  assign RDATA   = r_rdata;
  assign ERR     = r_err;

endmodule : raccoon_master
`default_nettype wire

// File: tb/tb_raccoon_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_raccoon_master
// Description : Directed self-checking bench for raccoon_master. Drives the
//               ring input and client port from one linear sequence and
//               checks the ring output and client completion signals against
//               hand-computed packets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_raccoon_master;

  logic        CLK;
  logic        RST_N;
  logic [78:0] RaccIn;
  logic [78:0] RaccOut;
  logic        REQ;
  logic        WR;
  logic [31:0] ADDR;
  logic [31:0] WDATA;
  logic [3:0]  MASK;
  logic        ACK;
  logic [31:0] RDATA;
  logic        ERR;

  int n_vec;
  int n_fail;

  raccoon_master #(
    .MASTER_ID      (6'd1),
    .TIMEOUT_CYCLES (16'd16)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .RaccIn  (RaccIn),
    .RaccOut (RaccOut),
    .REQ     (REQ),
    .WR      (WR),
    .ADDR    (ADDR),
    .WDATA   (WDATA),
    .MASK    (MASK),
    .ACK     (ACK),
    .RDATA   (RDATA),
    .ERR     (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [78:0] obs, input logic [78:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [78:0] pkt(input logic v, input logic w, input logic r,
                                      input logic [7:0] id, input logic [3:0] m,
                                      input logic [31:0] d, input logic [31:0] a);
    return {v, w, r, id, m, d, a};
  endfunction

  initial begin
    n_vec  = 0;
    n_fail = 0;
    RST_N  = 1'b0;
    RaccIn = '0;
    REQ    = 1'b0;
    WR     = 1'b0;
    ADDR   = 32'd0;
    WDATA  = 32'd0;
    MASK   = 4'd0;

    // ---------------- reset state ----------------
    step();
    step();
    check("rst_raccout", RaccOut, 79'd0);
    check("rst_ack",     {78'd0, ACK}, 79'd0);
    check("rst_rdata",   {47'd0, RDATA}, 79'd0);
    check("rst_err",     {78'd0, ERR}, 79'd0);
    RST_N = 1'b1;
    step();

    // ---------------- read on an idle ring, ID 0x04 ----------------
    WR = 1'b0; ADDR = 32'h0001_0010; WDATA = 32'd0; MASK = 4'hF; REQ = 1'b1;
    step();
    step();
    check("rd_req_pkt", RaccOut, pkt(1'b1, 1'b0, 1'b0, 8'h04, 4'hF, 32'd0, 32'h0001_0010));
    step();
    check("rd_slot_after", RaccOut, 79'd0);
    step();
    step();
    RaccIn = pkt(1'b1, 1'b0, 1'b1, 8'h04, 4'd0, 32'hDEAD_BEEF, 32'd0);
    step();
    RaccIn = '0;
    check("rd_ack_early", {78'd0, ACK}, 79'd0);
    step();
    check("rd_ack",     {78'd0, ACK}, 79'd1);
    check("rd_rdata",   {47'd0, RDATA}, {47'd0, 32'hDEAD_BEEF});
    check("rd_err",     {78'd0, ERR}, 79'd0);
    check("rd_removed", RaccOut, 79'd0);
    REQ = 1'b0;
    step();
    check("rd_ack_pulse", {78'd0, ACK}, 79'd0);
    check("rd_rdata_hold", {47'd0, RDATA}, {47'd0, 32'hDEAD_BEEF});

    // ---------------- write, ID 0x05, with a foreign response in WAIT -------
    WR = 1'b1; ADDR = 32'h0000_0100; WDATA = 32'h1234_5678; MASK = 4'b0011; REQ = 1'b1;
    step();
    step();
    check("wr_req_pkt", RaccOut, pkt(1'b1, 1'b1, 1'b0, 8'h05, 4'b0011, 32'h1234_5678, 32'h0000_0100));
    RaccIn = pkt(1'b1, 1'b0, 1'b1, 8'h08, 4'hF, 32'hAAAA_5555, 32'h0000_0200);
    step();
    RaccIn = '0;
    step();
    check("foreign_resp_pass", RaccOut, pkt(1'b1, 1'b0, 1'b1, 8'h08, 4'hF, 32'hAAAA_5555, 32'h0000_0200));
    check("foreign_resp_noack", {78'd0, ACK}, 79'd0);
    RaccIn = pkt(1'b1, 1'b1, 1'b1, 8'h05, 4'd0, 32'hCAFE_F00D, 32'h0000_0100);
    step();
    RaccIn = '0;
    step();
    check("wr_ack",     {78'd0, ACK}, 79'd1);
    check("wr_rdata",   {47'd0, RDATA}, 79'd0);
    check("wr_removed", RaccOut, 79'd0);
    REQ = 1'b0;
    step();

    // ---------------- full ring for 20 cycles, then one empty slot, ID 0x06 --
    WR = 1'b0; ADDR = 32'h0000_0040; WDATA = 32'd0; MASK = 4'hF; REQ = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (i < 20)
        RaccIn = pkt(1'b1, 1'b0, 1'b0, 8'h0C, 4'hF, 32'h0000_1000 + i, 32'hA000_0000 + i);
      else
        RaccIn = '0;
      step();
      if (i >= 1 && i <= 20)
        check("full_pass", RaccOut,
              pkt(1'b1, 1'b0, 1'b0, 8'h0C, 4'hF, 32'h0000_1000 + (i - 1), 32'hA000_0000 + (i - 1)));
      if (i == 21)
        check("full_insert", RaccOut, pkt(1'b1, 1'b0, 1'b0, 8'h06, 4'hF, 32'd0, 32'h0000_0040));
    end
    RaccIn = pkt(1'b1, 1'b0, 1'b1, 8'h06, 4'd0, 32'h55AA_55AA, 32'd0);
    step();
    RaccIn = '0;
    step();
    check("full_ack",   {78'd0, ACK}, 79'd1);
    check("full_rdata", {47'd0, RDATA}, {47'd0, 32'h55AA_55AA});
    REQ = 1'b0;
    step();

    // ---------------- stale response of ours while IDLE ----------------
    RaccIn = pkt(1'b1, 1'b0, 1'b1, 8'h07, 4'd0, 32'h0BAD_0BAD, 32'd0);
    step();
    RaccIn = '0;
    step();
    check("stale_idle_removed", RaccOut, 79'd0);
    check("stale_idle_noack",   {78'd0, ACK}, 79'd0);
    check("stale_idle_rdata",   {47'd0, RDATA}, {47'd0, 32'h55AA_55AA});

    // ---------------- reset during WAIT ----------------
    WR = 1'b0; ADDR = 32'h0000_0200; MASK = 4'hF; REQ = 1'b1;
    step();
    step();
    check("rst_req_pkt", RaccOut, pkt(1'b1, 1'b0, 1'b0, 8'h07, 4'hF, 32'd0, 32'h0000_0200));
    step();
    RST_N = 1'b0;
    #2;
    check("midrst_raccout", RaccOut, 79'd0);
    check("midrst_ack",     {78'd0, ACK}, 79'd0);
    check("midrst_rdata",   {47'd0, RDATA}, 79'd0);
    check("midrst_err",     {78'd0, ERR}, 79'd0);
    REQ = 1'b0;
    step();
    RST_N = 1'b1;
    step();
    ADDR = 32'h0000_0300; REQ = 1'b1;
    step();
    step();
    check("postrst_req_pkt", RaccOut, pkt(1'b1, 1'b0, 1'b0, 8'h04, 4'hF, 32'd0, 32'h0000_0300));
    RaccIn = pkt(1'b1, 1'b0, 1'b1, 8'h07, 4'd0, 32'h7777_7777, 32'd0);
    step();
    RaccIn = '0;
    step();
    check("inflight_removed", RaccOut, 79'd0);
    check("inflight_noack",   {78'd0, ACK}, 79'd0);
    RaccIn = pkt(1'b1, 1'b0, 1'b1, 8'h04, 4'd0, 32'h1357_9BDF, 32'd0);
    step();
    RaccIn = '0;
    step();
    check("postrst_ack",   {78'd0, ACK}, 79'd1);
    check("postrst_rdata", {47'd0, RDATA}, {47'd0, 32'h1357_9BDF});
    REQ = 1'b0;
    step();

`ifdef RACCOON_MASTER_TIMEOUT_EN
    // ---------------- timeout after 16 WAIT cycles ----------------
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    step();
    WR = 1'b0; ADDR = 32'h0000_0400; MASK = 4'hF; REQ = 1'b1;
    step();
    step();
    check("tmo_req_pkt", RaccOut, pkt(1'b1, 1'b0, 1'b0, 8'h04, 4'hF, 32'd0, 32'h0000_0400));
    repeat (15) step();
    check("tmo_ack_early", {78'd0, ACK}, 79'd0);
    step();
    check("tmo_ack",   {78'd0, ACK}, 79'd1);
    check("tmo_err",   {78'd0, ERR}, 79'd1);
    check("tmo_rdata", {47'd0, RDATA}, 79'd0);
    REQ = 1'b0;
    RaccIn = pkt(1'b1, 1'b0, 1'b1, 8'h04, 4'd0, 32'hFEED_FACE, 32'd0);
    step();
    RaccIn = '0;
    step();
    check("late_removed", RaccOut, 79'd0);
    check("late_noack",   {78'd0, ACK}, 79'd0);
    ADDR = 32'h0000_0404; REQ = 1'b1;
    step();
    step();
    check("tmo2_req_pkt", RaccOut, pkt(1'b1, 1'b0, 1'b0, 8'h05, 4'hF, 32'd0, 32'h0000_0404));
    RaccIn = pkt(1'b1, 1'b0, 1'b1, 8'h05, 4'd0, 32'h2468_ACE0, 32'd0);
    step();
    RaccIn = '0;
    step();
    check("tmo2_ack",   {78'd0, ACK}, 79'd1);
    check("tmo2_err",   {78'd0, ERR}, 79'd0);
    check("tmo2_rdata", {47'd0, RDATA}, {47'd0, 32'h2468_ACE0});
    REQ = 1'b0;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_raccoon_master
`default_nettype wire
